// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and helpers for the fetch front end
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // A fetch address must sit on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, instruction fetch and IF/ID output register
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned     MEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [XLEN-1:0] DEPTH_WORDS = XLEN'(MEM_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic            handshake;
  logic            in_range;

  // The output register can take a new word when empty or being drained.
  assign accept    = !id_valid || id_ready;
  assign handshake = id_valid && id_ready;
  assign in_range  = {2'b00, pc_q[XLEN-1:2]} < DEPTH_WORDS;
  assign imem_addr = pc_q;

  // PC, IF/ID register and fault state; redirect beats fault hold beats fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= NOP_INSTR;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      // Held instruction is dropped even if decode takes it this cycle.
      id_valid <= 1'b0;
      pc_q     <= redirect_pc;
      if (is_misaligned(redirect_pc)) begin
        fetch_fault <= 1'b1;
        fault_pc    <= redirect_pc;
      end else begin
        fetch_fault <= 1'b0;
      end
    end else if (fetch_fault) begin
      if (accept) begin
        id_valid <= 1'b0;
      end
    end else if (accept) begin
      if (fetch_en) begin
        if (in_range) begin
          id_valid <= 1'b1;
          id_pc    <= pc_q;
          id_instr <= imem_instr;
          pc_q     <= pc_q + PC_STEP;
        end else begin
          id_valid    <= 1'b0;
          fetch_fault <= 1'b1;
          fault_pc    <= pc_q;
        end
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

  // Count every decode handshake, including one that a redirect discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (handshake) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (default depth)
  logic        en, rdy, redir;
  logic [31:0] rpc;
  logic [31:0] addr, instr, idpc, idinstr, fpc, cnt;
  logic        vld, fault;

  // small instance (depth of four words)
  logic        en4, rdy4, redir4;
  logic [31:0] rpc4;
  logic [31:0] addr4, instr4, idpc4, idinstr4, fpc4, cnt4;
  logic        vld4, fault4;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0: return 32'h1111_1111;
      32'h4: return 32'h2222_2222;
      32'h8: return 32'h3333_3333;
      default: return {8'hA5, a[23:0]};
    endcase
  endfunction

  assign instr  = word_at(addr);
  assign instr4 = word_at(addr4);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(en), .imem_addr(addr), .imem_instr(instr),
    .redirect_valid(redir), .redirect_pc(rpc), .id_valid(vld), .id_ready(rdy),
    .id_pc(idpc), .id_instr(idinstr), .fetch_fault(fault), .fault_pc(fpc),
    .fetch_count(cnt)
  );

  fetch_stage #(.MEM_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .fetch_en(en4), .imem_addr(addr4), .imem_instr(instr4),
    .redirect_valid(redir4), .redirect_pc(rpc4), .id_valid(vld4), .id_ready(rdy4),
    .id_pc(idpc4), .id_instr(idinstr4), .fetch_fault(fault4), .fault_pc(fpc4),
    .fetch_count(cnt4)
  );

  // Behavioural model: architectural state of one fetch stage.
  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] iw;
    logic        flt;
    logic [31:0] fpc;
    logic [31:0] n;
  } mstate_t;

  mstate_t m, m4;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.pc = 32'h0; s.v = 0; s.ipc = 0; s.iw = 32'h13; s.flt = 0; s.fpc = 0; s.n = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic e, input logic r,
                                     input logic rd, input logic [31:0] t,
                                     input int unsigned depth);
    mstate_t x = s;
    bit take = !s.v || r;
    if (s.v && r) x.n = s.n + 1;
    if (rd) begin
      x.v = 0;
      x.pc = t;
      if (t % 4 != 0) begin x.flt = 1; x.fpc = t; end
      else x.flt = 0;
    end else if (s.flt) begin
      if (take) x.v = 0;
    end else if (take) begin
      if (!e) x.v = 0;
      else if ((s.pc / 4) < depth) begin
        x.v = 1; x.ipc = s.pc; x.iw = word_at(s.pc); x.pc = s.pc + 4;
      end else begin
        x.v = 0; x.flt = 1; x.fpc = s.pc;
      end
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m  = m_reset();
      m4 = m_reset();
    end else begin
      m  = m_step(m,  en,  rdy,  redir,  rpc,  1024);
      m4 = m_step(m4, en4, rdy4, redir4, rpc4, 4);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m.imem_addr", addr, m.pc);
      chk("m.id_valid", {31'b0, vld}, {31'b0, m.v});
      chk("m.id_pc", idpc, m.ipc);
      chk("m.id_instr", idinstr, m.iw);
      chk("m.fetch_fault", {31'b0, fault}, {31'b0, m.flt});
      chk("m.fault_pc", fpc, m.fpc);
      chk("m.fetch_count", cnt, m.n);
      chk("m4.imem_addr", addr4, m4.pc);
      chk("m4.id_valid", {31'b0, vld4}, {31'b0, m4.v});
      chk("m4.id_pc", idpc4, m4.ipc);
      chk("m4.fetch_fault", {31'b0, fault4}, {31'b0, m4.flt});
      chk("m4.fault_pc", fpc4, m4.fpc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    en = 0; rdy = 0; redir = 0; rpc = 0;
    en4 = 0; rdy4 = 1; redir4 = 0; rpc4 = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.id_valid", {31'b0, vld}, 32'd0);
    chk("rst.id_instr", idinstr, 32'h0000_0013);
    chk("rst.imem_addr", addr, 32'h0);
    rst_n = 1;
    started = 1;

    // sequential fetch at full throughput
    en = 1; rdy = 1; en4 = 1;
    step();
    chk("seq1.id_valid", {31'b0, vld}, 32'd1);
    chk("seq1.id_pc", idpc, 32'h0);
    chk("seq1.id_instr", idinstr, 32'h1111_1111);
    step();
    chk("seq2.id_pc", idpc, 32'h4);
    chk("seq2.id_instr", idinstr, 32'h2222_2222);
    step();
    chk("seq3.id_pc", idpc, 32'h8);
    chk("seq3.id_instr", idinstr, 32'h3333_3333);
    step();
    chk("seq4.fetch_count", cnt, 32'd3);
    chk("d4.last_pc", idpc4, 32'hC);
    step();
    chk("d4.fault", {31'b0, fault4}, 32'd1);
    chk("d4.fault_pc", fpc4, 32'h10);
    chk("d4.id_valid", {31'b0, vld4}, 32'd0);
    step();
    chk("d4.no_more_valid", {31'b0, vld4}, 32'd0);

    // asynchronous reset between edges
    rst_n = 0;
    #1;
    chk("arst.id_valid", {31'b0, vld}, 32'd0);
    chk("arst.imem_addr", addr, 32'h0);
    chk("arst.fetch_count", cnt, 32'd0);
    #1;
    rst_n = 1;
    en4 = 0;

    // stall on the first instruction
    rdy = 0;
    step();
    repeat (3) step();
    chk("stall.id_pc", idpc, 32'h0);
    chk("stall.id_instr", idinstr, 32'h1111_1111);
    chk("stall.imem_addr", addr, 32'h4);
    rdy = 1;
    step();
    chk("release.id_pc", idpc, 32'h4);
    rdy = 0;
    step();

    // redirect while stalled
    redir = 1; rpc = 32'h40;
    step();
    redir = 0;
    chk("redir.id_valid", {31'b0, vld}, 32'd0);
    chk("redir.imem_addr", addr, 32'h40);
    step();
    chk("redir.id_pc", idpc, 32'h40);
    rdy = 1;

    // misaligned redirect, fault hold, then clearing redirect
    redir = 1; rpc = 32'h42;
    step();
    redir = 0;
    chk("mis.fault", {31'b0, fault}, 32'd1);
    chk("mis.fault_pc", fpc, 32'h42);
    repeat (3) step();
    chk("mis.hold_valid", {31'b0, vld}, 32'd0);
    redir = 1; rpc = 32'h80;
    step();
    redir = 0;
    chk("clr.fault", {31'b0, fault}, 32'd0);
    step();
    chk("clr.id_pc", idpc, 32'h80);
    chk("clr.id_valid", {31'b0, vld}, 32'd1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
